// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg                                                                    |
// | Shared timing constants, pattern encodings, colours and helper functions.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_GRAD = 2'd2,
    MODE_BOX  = 2'd3
  } mode_t;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_NAVY    = 24'h000040;
  localparam logic [7:0]  GRAD_BLUE   = 8'h80;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
  } axis_t;

  // Bar index from a compare chain against multiples of the bar width
  function automatic logic [2:0] bar_index(input logic [10:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 11'(k * (H_ACTIVE / 8))) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

  // One frame of bounce motion; max_pos is the largest legal top-left coordinate
  function automatic axis_t axis_step(input axis_t cur, input logic [10:0] max_pos,
                                      input logic [10:0] step);
    axis_t nxt;
    nxt = cur;
    if (cur.dir == DIR_POS) begin
      if (cur.pos + step > max_pos) begin
        nxt.dir = DIR_NEG;
        nxt.pos = cur.pos - step;
      end else begin
        nxt.pos = cur.pos + step;
      end
    end else begin
      if (cur.pos < step) begin
        nxt.dir = DIR_POS;
        nxt.pos = cur.pos + step;
      end else begin
        nxt.pos = cur.pos - step;
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce                                                               |
// | Synchronises an active-low key and emits one pulse per debounced press.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYC = 800000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC - 1);

  logic [1:0]         r_sync;
  logic               r_stable;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
        // Accepting a new level while stable was high means a 1->0 edge
        r_press  <= r_stable;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pattern_gen                                                            |
// | Four-pattern pixel source with frame-aligned mode switching, 2-clk latency.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int BOX_SIZE     = 64,
  parameter int BOX_STEP     = 2,
  parameter int DEBOUNCE_CYC = 800000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        pix_de,
  input  logic        frame_start,
  input  logic        key_n,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        rgb_de,
  output logic [1:0]  mode
);

  localparam logic [10:0] c_box_size = 11'(BOX_SIZE);
  localparam logic [10:0] c_box_step = 11'(BOX_STEP);
  localparam logic [10:0] c_x_max    = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_y_max    = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_x_last   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] c_y_last   = 11'(V_ACTIVE - 1);

  logic        w_press;
  mode_t       r_mode;
  mode_t       r_pending;
  axis_t       r_ax;
  axis_t       r_ay;

  logic [2:0]  w_bar;
  logic        w_grid;
  logic        w_in_box;
  logic [23:0] w_colour;

  logic        r_s1_de;
  logic [2:0]  r_s1_bar;
  logic        r_s1_grid;
  logic        r_s1_box;
  logic [7:0]  r_s1_gr;
  logic [7:0]  r_s1_gg;

  logic [23:0] r_rgb;
  logic        r_rgb_de;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_n),
    .o_press (w_press)
  );

  // Mode and box only change at frame start so the visible frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_BARS;
      r_pending <= MODE_BARS;
      r_ax      <= '{pos: 11'd0, dir: DIR_POS};
      r_ay      <= '{pos: 11'd0, dir: DIR_POS};
    end else begin
      if (frame_start) begin
        r_mode <= r_pending;
        r_ax   <= axis_step(r_ax, c_x_max, c_box_step);
        r_ay   <= axis_step(r_ay, c_y_max, c_box_step);
      end
      if (w_press) r_pending <= mode_t'(r_pending + 2'd1);
    end
  end

  assign w_bar    = bar_index(pix_x);
  assign w_grid   = (pix_x[5:0] == 6'd0) || (pix_y[5:0] == 6'd0) ||
                    (pix_x == c_x_last) || (pix_y == c_y_last);
  assign w_in_box = (pix_x >= r_ax.pos) && (pix_x < r_ax.pos + c_box_size) &&
                    (pix_y >= r_ay.pos) && (pix_y < r_ay.pos + c_box_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_de   <= 1'b0;
      r_s1_bar  <= 3'd0;
      r_s1_grid <= 1'b0;
      r_s1_box  <= 1'b0;
      r_s1_gr   <= 8'd0;
      r_s1_gg   <= 8'd0;
    end else begin
      r_s1_de   <= pix_de;
      r_s1_bar  <= w_bar;
      r_s1_grid <= w_grid;
      r_s1_box  <= w_in_box;
      r_s1_gr   <= pix_x[9:2];
      r_s1_gg   <= pix_y[9:2];
    end
  end

  always_comb begin
    w_colour = COL_BLACK;
    case (r_mode)
      MODE_BARS: w_colour = bar_colour(r_s1_bar);
      MODE_GRID: w_colour = r_s1_grid ? COL_WHITE : COL_BLACK;
      MODE_GRAD: w_colour = {r_s1_gr, r_s1_gg, GRAD_BLUE};
      MODE_BOX:  w_colour = r_s1_box ? COL_RED : COL_NAVY;
      default:   w_colour = COL_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb    <= COL_BLACK;
      r_rgb_de <= 1'b0;
    end else begin
      r_rgb_de <= r_s1_de;
      r_rgb    <= r_s1_de ? w_colour : COL_BLACK;
    end
  end

  assign rgb_r  = r_rgb[23:16];
  assign rgb_g  = r_rgb[15:8];
  assign rgb_b  = r_rgb[7:0];
  assign rgb_de = r_rgb_de;
  assign mode   = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_pattern_gen                                                         |
// | Randomised and directed bench against an arithmetic pattern model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vga_pattern_gen;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;
  logic        pix_de = 1'b0;
  logic        frame_start = 1'b0;
  logic        key_n = 1'b1;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        rgb_de;
  logic [1:0]  mode;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int m_pending = 0;
  int m_frames = 0;
  logic [23:0] bar_tab [8];

  assign rgb = {rgb_r, rgb_g, rgb_b};

  vga_pattern_gen #(
    .BOX_SIZE(64), .BOX_STEP(2), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .frame_start(frame_start), .key_n(key_n), .rgb_r(rgb_r), .rgb_g(rgb_g),
    .rgb_b(rgb_b), .rgb_de(rgb_de), .mode(mode)
  );

  always #5 clk = ~clk;

  // Box position after n frames: a triangle wave of slope 2 bouncing in [0, span]
  function automatic int tri_wave(input int n, input int span);
    int t;
    t = (2 * n) % (2 * span);
    return (t <= span) ? t : 2 * span - t;
  endfunction

  function automatic logic [23:0] ref_rgb(input int md, input int x, input int y, input int frames);
    int bx, by;
    bx = tri_wave(frames, 800 - 64);
    by = tri_wave(frames, 600 - 64);
    case (md)
      0: return bar_tab[x / 100];
      1: return (x % 64 == 0 || y % 64 == 0 || x == 799 || y == 599) ? 24'hFFFFFF : 24'h000000;
      2: return {8'((x / 4) % 256), 8'((y / 4) % 256), 8'h80};
      default: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFF0000 : 24'h000040;
    endcase
  endfunction

  task automatic drive_pix(input int x, input int y, input logic de);
    @(posedge clk); #1;
    pix_x = 11'(x); pix_y = 11'(y); pix_de = de;
  endtask

  // Leaves the bench just after the edge where the pixel reaches rgb_*
  task automatic send_pixel(input int x, input int y);
    drive_pix(x, y, 1'b1);
    drive_pix(0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    pix_de = 1'b0; frame_start = 1'b1;
    m_mode = m_pending; m_frames++;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic key_press(input int low);
    @(posedge clk); #1 key_n = 1'b0;
    repeat (low) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    checks++; if (rgb_de !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", rgb_de); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    rst_n = 1'b1;
  endtask

  task automatic test_bars();
    int x;
    drive_pix(0, 0, 1'b1);
    drive_pix(0, 0, 1'b0);
    checks++; if (rgb_de !== 1'b0) begin errors++; $display("FAIL bars_latency1 got de=%b want 0", rgb_de); end
    @(posedge clk); #1;
    checks++; if (rgb !== 24'hFFFFFF || rgb_de !== 1'b1)
      begin errors++; $display("FAIL bars_x0 got %h de=%b want FFFFFF de=1", rgb, rgb_de); end
    send_pixel(750, 0);
    checks++; if (rgb !== 24'h000000 || rgb_de !== 1'b1)
      begin errors++; $display("FAIL bars_x750 got %h de=%b want 000000 de=1", rgb, rgb_de); end
    for (int k = 0; k < 8; k++) begin
      x = k * 100 + ((k % 2 == 0) ? 99 : 0);
      send_pixel(x, $urandom_range(0, 599));
      checks++; if (rgb !== bar_tab[k])
        begin errors++; $display("FAIL bars_edge x=%0d got %h want %h", x, rgb, bar_tab[k]); end
    end
  endtask

  task automatic test_key();
    key_press(10);
    pulse_frame();
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL key_short got mode %0d want 0", mode); end
    key_press(40);
    m_pending = (m_pending + 1) % 4;
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL key_before_frame got mode %0d want 0", mode); end
    pulse_frame();
    checks++; if (mode !== 2'(m_mode) || m_mode != 1)
      begin errors++; $display("FAIL key_after_frame got mode %0d want 1", mode); end
  endtask

  task automatic test_random_stream(input int n);
    logic [24:0] q[$];
    logic [24:0] e;
    int x, y;
    logic de;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        e = q.pop_front();
        checks++;
        if (rgb !== e[23:0] || rgb_de !== e[24])
          begin errors++; $display("FAIL stream mode=%0d got %h de=%b want %h de=%b", m_mode, rgb, rgb_de, e[23:0], e[24]); end
      end
      if (i < n) begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 599);
        de = ($urandom_range(0, 3) != 0);
        pix_x = 11'(x); pix_y = 11'(y); pix_de = de;
        q.push_back({de, de ? ref_rgb(m_mode, x, y, m_frames) : 24'h0});
      end else begin
        pix_de = 1'b0;
      end
    end
  endtask

  task automatic test_grid();
    send_pixel(64, 5);
    checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL grid_64_5 got %h want FFFFFF", rgb); end
    send_pixel(65, 5);
    checks++; if (rgb !== 24'h000000) begin errors++; $display("FAIL grid_65_5 got %h want 000000", rgb); end
    send_pixel(799, 300);
    checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL grid_799_300 got %h want FFFFFF", rgb); end
    test_random_stream(60);
  endtask

  task automatic test_grad();
    send_pixel(400, 256);
    checks++; if (rgb !== 24'h644080) begin errors++; $display("FAIL grad_400_256 got %h want 644080", rgb); end
    test_random_stream(60);
  endtask

  task automatic test_box();
    int bx, by, ox;
    test_random_stream(60);
    for (int f = 0; f < 800; f++) begin
      pulse_frame();
      bx = tri_wave(m_frames, 736);
      by = tri_wave(m_frames, 536);
      send_pixel(bx, by);
      checks++; if (rgb !== 24'hFF0000)
        begin errors++; $display("FAIL box_corner f=%0d (%0d,%0d) got %h want FF0000", m_frames, bx, by, rgb); end
      send_pixel(bx + 63, by + 63);
      checks++; if (rgb !== 24'hFF0000)
        begin errors++; $display("FAIL box_far f=%0d (%0d,%0d) got %h want FF0000", m_frames, bx + 63, by + 63, rgb); end
      ox = (bx >= 1) ? bx - 1 : bx + 64;
      send_pixel(ox, by);
      checks++; if (rgb !== 24'h000040)
        begin errors++; $display("FAIL box_out f=%0d (%0d,%0d) got %h want 000040", m_frames, ox, by, rgb); end
    end
    test_random_stream(60);
  endtask

  task automatic test_reset_mid();
    drive_pix(100, 100, 1'b1);
    drive_pix(0, 0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    m_mode = 0; m_pending = 0; m_frames = 0;
    #1;
    checks++; if (rgb_de !== 1'b0 || rgb !== 24'h0)
      begin errors++; $display("FAIL rst_mid_out got %h de=%b want 000000 de=0", rgb, rgb_de); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mid_mode got %0d want 0", mode); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rgb_de !== 1'b0) begin errors++; $display("FAIL rst_mid_lat1 got de=%b want 0", rgb_de); end
    @(posedge clk); #1;
    pix_de = 1'b0;
    checks++; if (rgb_de !== 1'b1 || rgb !== 24'hFFFFFF)
      begin errors++; $display("FAIL rst_mid_lat2 got %h de=%b want FFFFFF de=1", rgb, rgb_de); end
  endtask

  task automatic test_multi_press();
    for (int i = 0; i < 5; i++) key_press(40);
    m_pending = (m_pending + 5) % 4;
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL multi_before got mode %0d want 0", mode); end
    pulse_frame();
    checks++; if (mode !== 2'(m_mode) || m_mode != 1)
      begin errors++; $display("FAIL multi_after got mode %0d want 1", mode); end
    test_random_stream(40);
  endtask

  task automatic test_coincident();
    bit seen;
    int old_pending;
    seen = 1'b0;
    old_pending = m_pending;
    @(posedge clk); #1 key_n = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (dut.u_key_debounce.o_press === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL coinc_press_timeout got none want press within 200 clk");
    end else begin
      frame_start = 1'b1;
      m_mode = old_pending; m_pending = (old_pending + 1) % 4; m_frames++;
      @(posedge clk); #1;
      frame_start = 1'b0;
      key_n = 1'b1;
      checks++; if (mode !== 2'(old_pending))
        begin errors++; $display("FAIL coinc_same_frame got mode %0d want %0d", mode, old_pending); end
      repeat (40) @(posedge clk);
      pulse_frame();
      checks++; if (mode !== 2'(m_mode))
        begin errors++; $display("FAIL coinc_next_frame got mode %0d want %0d", mode, m_mode); end
      test_random_stream(40);
    end
    key_n = 1'b1;
  endtask

  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000; bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    test_reset();
    test_bars();
    test_random_stream(60);
    test_key();
    test_grid();
    key_press(40); m_pending = (m_pending + 1) % 4; pulse_frame();
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL mode_to_grad got %0d want 2", mode); end
    test_grad();
    key_press(40); m_pending = (m_pending + 1) % 4; pulse_frame();
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL mode_to_box got %0d want 3", mode); end
    test_box();
    test_reset_mid();
    test_multi_press();
    test_coincident();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
